rgb_frame_reader: RTL and testbench

- Frame-fetch stage that sits directly upstream of the RGB→YUV converter.
- Walks a planar-per-line RGB frame in pixel memory, issuing one read address per pixel on `mem_addr`/`mem_read`, and captures the 24-bit `mem_q` word.
- Presents pixels as a valid/ready stream with start-of-frame, end-of-line and end-of-frame flags, sustaining one pixel per clock under continuous `pix_ready`.
- Memory layout per line is R row, G row, B row, each `H_ACTIVE` bytes. Pixel (x, y) is addressed at `base + y*3*H_ACTIVE + x`; the memory returns {R, G, B} combinationally from the +0, +H_ACTIVE and +2·H_ACTIVE planes.

---
 rtl/rgb_frame_pkg.sv | 36 +++
 rtl/pix_skid_fifo.sv | 75 +++++++
 rtl/rgb_frame_reader.sv | 141 ++++++++++++++
 tb/tb_rgb_frame_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_frame_pkg.sv
// ============================================================================
// Module : rgb_frame_pkg
// Shared constants, FSM encoding and FIFO entry layout for the RGB frame reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rgb_frame_pkg;

  localparam int unsigned H_ACTIVE_DEF = 1280;
  localparam int unsigned V_ACTIVE_DEF = 720;

  // FIFO entry: {sof, eol, eof, R, G, B}
  localparam int unsigned FIFO_W  = 27;
  localparam int unsigned FLD_SOF = 26;
  localparam int unsigned FLD_EOL = 25;
  localparam int unsigned FLD_EOF = 24;
  localparam int unsigned FLD_R   = 16;
  localparam int unsigned FLD_G   = 8;
  localparam int unsigned FLD_B   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } frame_state_e;

  function automatic logic [FIFO_W-1:0] pack_entry(input logic sof, input logic eol,
                                                   input logic eof, input logic [23:0] rgb);
    return {sof, eol, eof, rgb};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pix_skid_fifo.sv
// ============================================================================
// Module : pix_skid_fifo
// Two-entry FIFO with simultaneous push/pop; entry 0 is always the head.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pix_skid_fifo
  import rgb_frame_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] d0_q, d0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [1:0]       count_q, count_d;
  logic             w_pop;
  logic             w_push;

  // Pops on empty and pushes on full-without-pop are dropped.
  assign w_pop  = pop_i && (count_q != 2'd0);
  assign w_push = push_i && ((count_q != 2'd2) || w_pop);

  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (count_q == 2'd0) d0_d = wdata_i;
        else                 d1_d = wdata_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        d0_d    = d1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          d0_d = wdata_i;
        end else begin
          d0_d = d1_q;
          d1_d = wdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q    <= '0;
      d1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = d0_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/rgb_frame_reader.sv
// ============================================================================
// Module : rgb_frame_reader
// Walks a line-planar RGB frame in memory and streams pixels with frame flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rgb_frame_reader
  import rgb_frame_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  input  logic [23:0]       mem_q_i,
  output logic [7:0]        pix_r_o,
  output logic [7:0]        pix_g_o,
  output logic [7:0]        pix_b_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_sof_o,
  output logic              pix_eol_o,
  output logic              pix_eof_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(3 * H_ACTIVE);

  frame_state_e      state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic [FIFO_W-1:0] w_head;
  logic [1:0]        w_count;
  logic              w_pop;
  logic              w_last_x;
  logic              w_last_y;
  logic [FIFO_W-1:0] w_entry;

  assign w_last_x = (x_q == XW'(H_ACTIVE - 1));
  assign w_last_y = (y_q == YW'(V_ACTIVE - 1));
  assign w_pop    = pix_valid_o && pix_ready_i;
  assign w_entry  = pack_entry((x_q == '0) && (y_q == '0), w_last_x, w_last_x && w_last_y, mem_q_i);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    line_base_d = line_base_q;
    base_d      = base_q;
    mem_read_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_FETCH;
          base_d      = base_addr_i;
          x_d         = '0;
          y_d         = '0;
          line_base_d = '0;
        end
      end
      ST_FETCH: begin
        // A slot frees up this cycle when the head is being accepted.
        mem_read_o = (w_count < 2'd2) || ((w_count == 2'd2) && w_pop);
        if (mem_read_o) begin
          if (w_last_x) begin
            x_d         = '0;
            line_base_d = line_base_q + LINE_STRIDE;
            if (w_last_y) begin
              y_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the final entry is accepted so frame_done follows immediately.
        if ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      base_q      <= base_d;
    end
  end

  pix_skid_fifo #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (mem_read_o),
    .pop_i   (w_pop),
    .wdata_i (w_entry),
    .head_o  (w_head),
    .count_o (w_count)
  );

  assign mem_addr_o   = base_q + line_base_q + ADDR_W'(x_q);
  assign pix_valid_o  = (w_count != 2'd0);
  assign pix_r_o      = w_head[FLD_R +: 8];
  assign pix_g_o      = w_head[FLD_G +: 8];
  assign pix_b_o      = w_head[FLD_B +: 8];
  assign pix_sof_o    = pix_valid_o && w_head[FLD_SOF];
  assign pix_eol_o    = pix_valid_o && w_head[FLD_EOL];
  assign pix_eof_o    = pix_valid_o && w_head[FLD_EOF];
  assign busy_o       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign frame_done_o = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rgb_frame_reader.sv
// ============================================================================
// Module : tb_rgb_frame_reader
// Scoreboard bench for rgb_frame_reader with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rgb_frame_reader;

  localparam int unsigned H = 1280;
  localparam int unsigned V = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [23:0] mem_q;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid, pix_ready, pix_sof, pix_eol, pix_eof, busy, frame_done;

  int tests = 0;
  int fails = 0;

  logic [26:0] exp_q[$];
  logic [31:0] addr_q[$];
  int          ready_mode = 0;
  int          occ = 0;
  bit          done_exp = 0;
  bit          prev_stall = 0;
  logic [26:0] prev_pix = '0;
  int          pix_cnt = 0;
  int          eol_cnt = 0;

  rgb_frame_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .mem_addr_o   (mem_addr),
    .mem_read_o   (mem_read),
    .mem_q_i      (mem_q),
    .pix_r_o      (pix_r),
    .pix_g_o      (pix_g),
    .pix_b_o      (pix_b),
    .pix_valid_o  (pix_valid),
    .pix_ready_i  (pix_ready),
    .pix_sof_o    (pix_sof),
    .pix_eol_o    (pix_eol),
    .pix_eof_o    (pix_eof),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'h9E3779B1;
    return t[23:16] ^ t[31:24] ^ a[7:0];
  endfunction

  always_comb mem_q = {mb(mem_addr), mb(mem_addr + H), mb(mem_addr + 2 * H)};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b0;
    endcase
  end

  // Monitor: pixels, read addresses, occupancy, stalls and completion.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      logic [26:0] cur;
      bit          hs;
      cur = {pix_sof, pix_eol, pix_eof, pix_r, pix_g, pix_b};
      hs  = pix_valid && pix_ready;
      if (frame_done || done_exp) begin
        chk("frame_done", {62'd0, frame_done, busy}, {62'd0, done_exp, 1'b0});
      end
      done_exp = 0;
      if (prev_stall) chk("stall_stable", {36'd0, pix_valid, cur}, {36'd0, 1'b1, prev_pix});
      if (hs) begin
        if (exp_q.size() == 0) chk("pix_extra", 64'(cur), 64'hDEAD);
        else chk("pixel", 64'(cur), 64'(exp_q.pop_front()));
        pix_cnt++;
        if (pix_eol) eol_cnt++;
        if (pix_eof) done_exp = 1;
      end
      if (mem_read) begin
        if (occ >= 2 && !hs) chk("read_when_full", 64'(occ), 64'd1);
        if (addr_q.size() == 0) chk("read_extra", 64'(mem_addr), 64'hDEAD);
        else chk("read_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
      end
      occ = occ + int'(mem_read) - int'(hs);
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur;
    end
  end

  task automatic push_frame(input logic [31:0] b);
    pix_cnt = 0;
    eol_cnt = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        logic [31:0] a;
        logic        eol;
        a   = b + 32'(y * 3 * H) + 32'(x);
        eol = (x == H - 1);
        addr_q.push_back(a);
        exp_q.push_back({(x == 0 && y == 0), eol, eol && (y == V - 1),
                         mb(a), mb(a + H), mb(a + 2 * H)});
      end
    end
  endtask

  // Called just after a clock edge; start is sampled on the following edge.
  task automatic do_start(input logic [31:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1 start = 1'b0;
    base_addr = 32'hFFFF_0000;
    #1;
    chk("start_busy", 64'(busy), 64'd1);
    chk("first_read", {31'd0, mem_read, mem_addr}, {31'd0, 1'b1, b});
    @(posedge clk);
    #2;
    chk("first_valid_sof", {62'd0, pix_valid, pix_sof}, {62'd0, 2'b11});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #2;
      if (frame_done) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic frame_end_check();
    chk("pix_count", 64'(pix_cnt), 64'(H * V));
    chk("eol_count", 64'(eol_cnt), 64'(V));
    chk("queues_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
  endtask

  initial begin
    pix_ready = 1'b1;
    #2;
    chk("reset_outputs",
        {mem_addr, mem_read, pix_valid, pix_sof, pix_eol, pix_eof, pix_r, pix_g, pix_b, busy, frame_done},
        '0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Frame 1: base 0, always ready.
    ready_mode = 0;
    push_frame(32'h0);
    @(posedge clk); #1;
    do_start(32'h0);
    wait_done();
    frame_end_check();

    // Frame 2: base 0x100, random backpressure.
    ready_mode = 1;
    push_frame(32'h100);
    @(posedge clk); #1;
    do_start(32'h100);
    wait_done();
    frame_end_check();

    // Frame 3: ready held low for 10 cycles after start.
    @(posedge clk); #2 ready_mode = 2;
    push_frame(32'h300);
    @(posedge clk); #1;
    begin
      int reads;
      logic last_rd;
      start = 1'b1;
      base_addr = 32'h300;
      @(posedge clk);
      #1 start = 1'b0;
      reads = 0;
      last_rd = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        reads += int'(mem_read);
        last_rd = mem_read;
        @(posedge clk);
        #1;
      end
      chk("stall_reads", 64'(reads), 64'd2);
      chk("stall_read_off", 64'(last_rd), 64'd0);
      #1 ready_mode = 1;
    end
    wait_done();
    frame_end_check();

    // Frame 4: mid-frame start and start during frame_done are both ignored.
    @(posedge clk); #2 ready_mode = 0;
    push_frame(32'h400);
    @(posedge clk); #1;
    do_start(32'h400);
    repeat (1000) @(posedge clk);
    #1 start = 1'b1;
    base_addr = 32'h9999;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    start = 1'b1;
    base_addr = 32'h7777;
    frame_end_check();
    @(posedge clk);
    #2 start = 1'b0;
    chk("done_start_ignored", {62'd0, busy, frame_done}, 64'd0);
    push_frame(32'h800);
    do_start(32'h800);
    wait_done();
    frame_end_check();

    // Frame 5: reset mid-line, then a fresh frame at a new base.
    @(posedge clk); #2 ready_mode = 1;
    push_frame(32'h5000);
    @(posedge clk); #1;
    do_start(32'h5000);
    repeat (700) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_midframe_outputs",
        {mem_addr, mem_read, pix_valid, pix_sof, pix_eol, pix_eof, pix_r, pix_g, pix_b, busy, frame_done},
        '0);
    exp_q.delete();
    addr_q.delete();
    occ = 0;
    done_exp = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (5) @(posedge clk);
    #2 chk("post_rst_idle", {61'd0, busy, frame_done, mem_read}, 64'd0);
    push_frame(32'h20000);
    @(posedge clk); #1;
    do_start(32'h20000);
    wait_done();
    frame_end_check();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
